// File: rtl/memoria_dados_ctrl.sv
// Data-memory stage for the nRisc core: a DEPTH x DATA_W array behind a
// programmable wait-state FSM, with a combinational stall back to the core.
//
// Handshake: the core presents LerMem xor EscMem with Endereco/DadoEscrita and
// holds them stable while Ocupado is high. The access completes in the single
// cycle where Pronto is high; Ocupado is low in that cycle so the core advances
// at its closing edge. A request still visible during Pronto is the one that
// just completed and is not re-accepted. LerMem and EscMem together, or an
// address beyond DEPTH, completes immediately with ErroAcesso alongside Pronto.
module memoria_dados_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              LerMem,
    input  logic              EscMem,
    input  logic [ADDR_W-1:0] Endereco,
    input  logic [DATA_W-1:0] DadoEscrita,
    output logic [DATA_W-1:0] LeDado,
    output logic              Pronto,
    output logic              Ocupado,
    output logic              ErroAcesso,
    output logic [1:0]        estado_dbg
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ESPERA  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      CNT_INI   = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    estado_t           estado, prox_estado;
    logic [2:0]        cnt, prox_cnt;
    logic [ADDR_W-1:0] end_q;
    logic [DATA_W-1:0] dado_q;
    logic              esc_q;
    logic              erro_q;

    logic              pedido;
    logic              aceita;
    logic              erro_novo;
    logic              entra_conclui;
    logic [ADDR_W-1:0] sel_end;
    logic              sel_esc;
    logic              sel_erro;

    // Request decode on the live core inputs.
    always_comb begin
        pedido    = LerMem ^ EscMem;
        aceita    = LerMem | EscMem;
        erro_novo = (LerMem & EscMem) | ({1'b0, Endereco} >= DEPTH_LIM);
    end

    // Next-state and wait counter.
    always_comb begin
        prox_estado = estado;
        prox_cnt    = cnt;
        case (estado)
            OCIOSO: begin
                if (aceita) begin
                    if (erro_novo || (WAIT_STATES == 0)) begin
                        prox_estado = CONCLUI;
                    end else begin
                        prox_estado = ESPERA;
                        prox_cnt    = CNT_INI;
                    end
                end
            end
            ESPERA: begin
                if (cnt == 3'd0) begin
                    prox_estado = CONCLUI;
                end else begin
                    prox_cnt = cnt - 3'd1;
                end
            end
            CONCLUI: prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // The read that lands on the CONCLUI entry edge comes straight from the
    // inputs when there are no wait states, otherwise from the latched copy.
    always_comb begin
        entra_conclui = (prox_estado == CONCLUI) && (estado != CONCLUI);
        if (estado == OCIOSO) begin
            sel_end  = Endereco;
            sel_esc  = EscMem & ~LerMem;
            sel_erro = erro_novo;
        end else begin
            sel_end  = end_q;
            sel_esc  = esc_q;
            sel_erro = erro_q;
        end
    end

    // State, counter, request latch and read-data register.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cnt    <= 3'd0;
            end_q  <= '0;
            dado_q <= '0;
            esc_q  <= 1'b0;
            erro_q <= 1'b0;
            LeDado <= '0;
        end else begin
            estado <= prox_estado;
            cnt    <= prox_cnt;
            if (estado == OCIOSO && aceita) begin
                end_q  <= Endereco;
                dado_q <= DadoEscrita;
                esc_q  <= EscMem & ~LerMem;
                erro_q <= erro_novo;
            end
            if (entra_conclui) begin
                if (sel_erro) begin
                    LeDado <= '0;
                end else if (!sel_esc) begin
                    LeDado <= mem[sel_end[IDX_W-1:0]];
                end
            end
        end
    end

    // Array write commits on the edge leaving CONCLUI; a reset beforehand
    // forces OCIOSO and so drops the write.
    always_ff @(posedge Clock) begin
        if (estado == CONCLUI && esc_q && !erro_q) begin
            mem[end_q[IDX_W-1:0]] <= dado_q;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        Pronto     = (estado == CONCLUI);
        ErroAcesso = (estado == CONCLUI) && erro_q;
        Ocupado    = ((estado == OCIOSO) && pedido) || (estado == ESPERA);
        estado_dbg = estado;
    end

endmodule

// File: tb/tb_memoria_dados_ctrl.sv
// Bench for memoria_dados_ctrl: two instances (2 wait states / 256 words and
// 0 wait states / 128 words) driven from a vector table plus hand sequences.
module tb_memoria_dados_ctrl;

    localparam int WS_A = 2;
    localparam int WS_B = 0;

    logic       clk;
    logic       rst_n;

    logic       ler_a, esc_a, pronto_a, ocup_a, erro_a;
    logic [7:0] end_a, dado_a, ledado_a;
    logic [1:0] est_a;
    logic       ler_b, esc_b, pronto_b, ocup_b, erro_b;
    logic [7:0] end_b, dado_b, ledado_b;
    logic [1:0] est_b;

    int errors = 0;
    int checks = 0;
    int np_a = 0, np_b = 0;
    int nacc_a = 0, nacc_b = 0;

    logic [8:0] exp_q[$];

    typedef struct {
        int         u;
        logic       rd;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp_d;
        logic       exp_e;
    } vec_t;

    vec_t tab[14];

    memoria_dados_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(WS_A)) dut_a (
        .Clock(clk), .reset(rst_n), .LerMem(ler_a), .EscMem(esc_a),
        .Endereco(end_a), .DadoEscrita(dado_a), .LeDado(ledado_a),
        .Pronto(pronto_a), .Ocupado(ocup_a), .ErroAcesso(erro_a), .estado_dbg(est_a)
    );

    memoria_dados_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_STATES(WS_B)) dut_b (
        .Clock(clk), .reset(rst_n), .LerMem(ler_b), .EscMem(esc_b),
        .Endereco(end_b), .DadoEscrita(dado_b), .LeDado(ledado_b),
        .Pronto(pronto_b), .Ocupado(ocup_b), .ErroAcesso(erro_b), .estado_dbg(est_b)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every completion pulse to catch duplicates or missing ones.
    always @(negedge clk) begin
        if (pronto_a) np_a++;
        if (pronto_b) np_b++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic rd, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
        if (u == 0) begin
            ler_a = rd; esc_a = wr; end_a = a; dado_a = d;
        end else begin
            ler_b = rd; esc_b = wr; end_b = a; dado_b = d;
        end
    endtask

    function automatic logic pronto_of(input int u);
        return (u == 0) ? pronto_a : pronto_b;
    endfunction

    function automatic logic ocup_of(input int u);
        return (u == 0) ? ocup_a : ocup_b;
    endfunction

    function automatic logic erro_of(input int u);
        return (u == 0) ? erro_a : erro_b;
    endfunction

    function automatic logic [7:0] ledado_of(input int u);
        return (u == 0) ? ledado_a : ledado_b;
    endfunction

    // Driver: called just after a rising edge; leaves inputs held through
    // the completion cycle and returns just after the edge that closes it.
    task automatic access(input int u, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_d, input logic exp_e);
        int         ws;
        int         lat_exp;
        int         busy_exp;
        int         busy;
        int         cyc;
        bit         seen;
        logic [8:0] e;
        ws       = (u == 0) ? WS_A : WS_B;
        lat_exp  = exp_e ? 1 : ws + 1;
        busy_exp = (rd ^ wr) ? lat_exp : 0;
        exp_q.push_back({exp_e, exp_d});
        if (u == 0) nacc_a++; else nacc_b++;
        drive(u, rd, wr, a, d);
        busy = 0;
        seen = 0;
        for (cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (pronto_of(u)) begin
                seen = 1;
                check($sformatf("latency u%0d a%0h", u, a), cyc, lat_exp);
                check($sformatf("ocupado_in_conclui u%0d a%0h", u, a), ocup_of(u), 0);
                e = exp_q.pop_front();
                check($sformatf("ledado u%0d a%0h", u, a), ledado_of(u), e[7:0]);
                check($sformatf("erro u%0d a%0h", u, a), erro_of(u), e[8]);
            end else begin
                busy += ocup_of(u);
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout u%0d a%0h: got no Pronto expected Pronto", u, a);
            e = exp_q.pop_front();
        end
        check($sformatf("stall_cycles u%0d a%0h", u, a), busy, busy_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int u, input int n);
        drive(u, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Vector table: unit, read, write, address, data, expected LeDado, expected error
        tab[0]  = '{0, 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
        tab[1]  = '{0, 1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
        tab[2]  = '{0, 1'b0, 1'b1, 8'h20, 8'h11, 8'hA5, 1'b0};
        tab[3]  = '{0, 1'b1, 1'b1, 8'h20, 8'hEE, 8'h00, 1'b1};
        tab[4]  = '{0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h11, 1'b0};
        tab[5]  = '{0, 1'b0, 1'b1, 8'h05, 8'h22, 8'h11, 1'b0};
        tab[6]  = '{1, 1'b0, 1'b1, 8'h10, 8'h3C, 8'h00, 1'b0};
        tab[7]  = '{1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0};
        tab[8]  = '{1, 1'b0, 1'b1, 8'h90, 8'hFF, 8'h00, 1'b1};
        tab[9]  = '{1, 1'b1, 1'b0, 8'h90, 8'h00, 8'h00, 1'b1};
        tab[10] = '{1, 1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0};
        tab[11] = '{1, 1'b0, 1'b1, 8'h7F, 8'h81, 8'h3C, 1'b0};
        tab[12] = '{1, 1'b1, 1'b0, 8'h7F, 8'h00, 8'h81, 1'b0};
        tab[13] = '{1, 1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1};

        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ledado_a", ledado_a, 8'h00);
        check("reset pronto_a", pronto_a, 0);
        check("reset ocupado_a", ocup_a, 0);
        check("reset erro_a", erro_a, 0);
        check("reset estado_a", est_a, 2'd0);
        check("reset ledado_b", ledado_b, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            access(tab[i].u, tab[i].rd, tab[i].wr, tab[i].a, tab[i].d, tab[i].exp_d, tab[i].exp_e);
            idle(tab[i].u, 1);
        end

        // Reset during the wait states of a write of 0x77 to 0x05.
        drive(0, 1'b0, 1'b1, 8'h05, 8'h77);
        @(posedge clk);
        #1;
        check("abort in_espera", est_a, 2'd1);
        #2;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("abort estado", est_a, 2'd0);
        check("abort pronto", pronto_a, 0);
        check("abort ocupado", ocup_a, 0);
        check("abort ledado", ledado_a, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, 1'b1, 1'b0, 8'h05, 8'h00, 8'h22, 1'b0);

        // Back-to-back accesses, request held through each completion cycle.
        access(0, 1'b0, 1'b1, 8'h30, 8'h5A, 8'h22, 1'b0);
        access(0, 1'b0, 1'b1, 8'h31, 8'h6B, 8'h22, 1'b0);
        access(0, 1'b1, 1'b0, 8'h30, 8'h00, 8'h5A, 1'b0);
        access(0, 1'b1, 1'b0, 8'h31, 8'h00, 8'h6B, 1'b0);
        idle(0, 2);
        access(1, 1'b0, 1'b1, 8'h40, 8'hC3, 8'h00, 1'b1 & 1'b0);
        access(1, 1'b1, 1'b0, 8'h40, 8'h00, 8'hC3, 1'b0);
        access(1, 1'b0, 1'b1, 8'h41, 8'h96, 8'hC3, 1'b0);
        access(1, 1'b1, 1'b0, 8'h41, 8'h00, 8'h96, 1'b0);
        idle(1, 3);

        check("pronto_count_a", np_a, nacc_a);
        check("pronto_count_b", np_b, nacc_b);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memoria_dados_ctrl.md
Name: memoria_dados_ctrl

Overview:
- Data-memory stage directly downstream of the nRisc core.
- Consumes the core's EscMem/LerMem strobes, address and write data; returns LeDado.
- Holds a DEPTH x DATA_W storage array behind a programmable wait-state FSM.
- Drives a stall (Ocupado) back to the core so PC and register writes freeze until the access completes.

Parameters:
- DATA_W, 8: data width.
- ADDR_W, 8: address width.
- DEPTH, 256: number of words, valid range 1..2^ADDR_W.
- WAIT_STATES, 2: extra cycles per access, valid range 0..7.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- LerMem  in  1  read request from core.
- EscMem  in  1  write request from core.
- Endereco  in  ADDR_W  access address.
- DadoEscrita  in  DATA_W  write data.
- LeDado  out  DATA_W  registered read data.
- Pronto  out  1  one-cycle completion pulse.
- Ocupado  out  1  stall to core (combinational).
- ErroAcesso  out  1  one-cycle error pulse, coincident with Pronto.

Behaviour:
- Reset (reset=0, asynchronous):
  - State OCIOSO, wait counter 0, LeDado=0, Pronto=0, ErroAcesso=0.
  - Latched address/data/op cleared to 0.
  - Storage array is not cleared.
- States are OCIOSO, ESPERA and CONCLUI.
- OCIOSO:
  - A request is LerMem^EscMem=1. On a request, latch Endereco, DadoEscrita and op.
  - If WAIT_STATES>0, load counter=WAIT_STATES-1 and go to ESPERA; else go to CONCLUI.
  - LerMem=EscMem=1 is illegal: go to CONCLUI with an error flag set. There are no wait states and no array access.
  - Endereco>=DEPTH: same error path. Read data is 0 and the write is dropped.
- ESPERA:
  - Decrement the counter each cycle.
  - When counter==0, go to CONCLUI.
  - Inputs are ignored; the core holds them while stalled.
- CONCLUI (exactly one cycle):
  - Pronto=1.
  - For a legal write, the array is written at this clock edge.
  - For a legal read, LeDado<=array[latched addr] at the entry edge, so it is valid during CONCLUI.
  - For an error, ErroAcesso=1 and LeDado<=0.
  - Then go unconditionally to OCIOSO. A request still asserted during CONCLUI is the completed one and is never re-accepted.
- Ocupado = (state==OCIOSO && request) || state==ESPERA. It is 0 in CONCLUI, so the core advances at the CONCLUI edge.
- Latency: request seen at edge 0 -> Pronto high during cycle WAIT_STATES+1. The stall length is WAIT_STATES+1 cycles.
- Back-to-back accesses need one OCIOSO cycle between them, so throughput is one access per WAIT_STATES+2 cycles.
- LeDado holds its value until the next completed read or error; writes do not change it.
- Reset asserted mid-access: the access is aborted and an in-flight write is not committed. Outputs return to reset values immediately.

Test Plan:
- WAIT_STATES=2: write 0xA5 to 0x10, then read 0x10.
  - Required: Ocupado high 3 cycles per access and Pronto on the 3rd cycle after the request edge.
  - Required: LeDado=0xA5 during the read's CONCLUI cycle.
- WAIT_STATES=0: read 0x10 right after a write of 0x3C.
  - Required: Pronto in the cycle after the request, LeDado=0x3C, Ocupado high exactly 1 cycle.
- LerMem=EscMem=1 at 0x20, after address 0x20 was preloaded with 0x11.
  - Required: Pronto=ErroAcesso=1 after 1 cycle and LeDado=0.
  - Required: a later read of 0x20 returns 0x11.
- DEPTH=128: write 0xFF to 0x90, then read 0x90.
  - Required: both accesses pulse ErroAcesso and the read returns LeDado=0.
  - Required: address 0x10 is unchanged.
- reset=0 during ESPERA of a write of 0x77 to 0x05 (0x05 previously 0x22).
  - Required: immediate OCIOSO with Pronto=0 and Ocupado=0.
  - Required: after release, a read of 0x05 returns 0x22.
- Back-to-back with the request held high through CONCLUI.
  - Required: exactly one Pronto per access and no duplicate write.
